// File: rtl/debounce_pkg.sv
// Shared defaults and counter sizing for the push-button debounce bank.
package debounce_pkg;

    localparam int N_CH_DEF       = 4;
    localparam int STABLE_CNT_DEF = 4;
    localparam int HOLD_CNT_DEF   = 16;

    // Bits needed to encode values 0..n-1, never less than one bit.
    function automatic int cntWidth(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Button bus: sample strobe and raw inputs towards the bank, filtered levels and pulses back.
interface debounce_bank_if
    import debounce_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
);

    logic            tick;
    logic [N_CH-1:0] pushB_in;
    logic [N_CH-1:0] pushB_level;
    logic [N_CH-1:0] pushB_rise;
    logic [N_CH-1:0] pushB_fall;
    logic [N_CH-1:0] pushB_hold;

    modport master (
        output tick,
        output pushB_in,
        input  pushB_level,
        input  pushB_rise,
        input  pushB_fall,
        input  pushB_hold
    );

    modport slave (
        input  tick,
        input  pushB_in,
        output pushB_level,
        output pushB_rise,
        output pushB_fall,
        output pushB_hold
    );

endinterface

// File: rtl/debounce_ch.sv
// One debounced button: 2-FF synchroniser, tick-driven stability filter, hold timer, registered pulses.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF,
    parameter int HOLD_CNT   = HOLD_CNT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic pushIn,
    output logic level,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam int STAB_W = cntWidth(STABLE_CNT);
    localparam int HOLD_W = cntWidth(HOLD_CNT + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CNT);

    logic              sync1_r;
    logic              sync2_r;
    logic              level_r;
    logic [STAB_W-1:0] stabCnt_r;
    logic [HOLD_W-1:0] holdCnt_r;
    logic              holdFired_r;
    logic              levelOut_r;
    logic              rise_r;
    logic              fall_r;
    logic              hold_r;

    // Metastability synchroniser, runs every clk regardless of tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pushIn;
            sync2_r <= sync1_r;
        end
    end

    // Stability filter and hold timer; the hold timer is only meaningful while level is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r     <= 1'b0;
            stabCnt_r   <= '0;
            holdCnt_r   <= '0;
            holdFired_r <= 1'b0;
        end else begin
            if (tick) begin
                if (sync2_r != level_r) begin
                    if (stabCnt_r == STAB_LAST) begin
                        level_r   <= ~level_r;
                        stabCnt_r <= '0;
                    end else begin
                        stabCnt_r <= stabCnt_r + 1'b1;
                    end
                end else begin
                    stabCnt_r <= '0;
                end
            end else begin
                stabCnt_r <= stabCnt_r;
            end

            if (!level_r) begin
                holdCnt_r   <= '0;
                holdFired_r <= 1'b0;
            end else begin
                if (tick && (holdCnt_r != HOLD_MAX)) begin
                    holdCnt_r <= holdCnt_r + 1'b1;
                end else begin
                    holdCnt_r <= holdCnt_r;
                end
                if (holdCnt_r == HOLD_MAX) begin
                    holdFired_r <= 1'b1;
                end else begin
                    holdFired_r <= holdFired_r;
                end
            end
        end
    end

    // Output stage: edge pulses come from comparing the filter level with its delayed copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            levelOut_r <= 1'b0;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
            hold_r     <= 1'b0;
        end else begin
            levelOut_r <= level_r;
            rise_r     <= level_r & ~levelOut_r;
            fall_r     <= ~level_r & levelOut_r;
            hold_r     <= level_r & (holdCnt_r == HOLD_MAX) & ~holdFired_r;
        end
    end

    assign level = levelOut_r;
    assign rise  = rise_r;
    assign fall  = fall_r;
    assign hold  = hold_r;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced push-button channels sharing one sample strobe.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int STABLE_CNT = STABLE_CNT_DEF,
    parameter int HOLD_CNT   = HOLD_CNT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    debounce_bank_if.slave bus
);

    logic [N_CH-1:0] level_s;
    logic [N_CH-1:0] rise_s;
    logic [N_CH-1:0] fall_s;
    logic [N_CH-1:0] hold_s;

    for (genvar i = 0; i < N_CH; i++) begin : genCh
        debounce_ch #(
            .STABLE_CNT (STABLE_CNT),
            .HOLD_CNT   (HOLD_CNT)
        ) uCh (
            .clk    (clk),
            .reset  (reset),
            .tick   (bus.tick),
            .pushIn (bus.pushB_in[i]),
            .level  (level_s[i]),
            .rise   (rise_s[i]),
            .fall   (fall_s[i]),
            .hold   (hold_s[i])
        );
    end

    assign bus.pushB_level = level_s;
    assign bus.pushB_rise  = rise_s;
    assign bus.pushB_fall  = fall_s;
    assign bus.pushB_hold  = hold_s;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: latency, glitch rejection, hold, slow tick, reset, bounce.
module tb_debounce_bank;
    import debounce_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   tickPeriod  = 1;

    debounce_bank_if #(.N_CH(4)) bus ();

    debounce_bank #(
        .N_CH       (4),
        .STABLE_CNT (4),
        .HOLD_CNT   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic stepClk();
        @(posedge clk);
        #1;
        cyc++;
        bus.tick = ((cyc % tickPeriod) == 0);
    endtask

    task automatic applyReset();
        reset        = 1'b1;
        bus.pushB_in = 4'b0000;
        stepClk();
        stepClk();
        reset    = 1'b0;
        cyc      = 0;
        bus.tick = 1'b1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.tick     = 1'b1;
        bus.pushB_in = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            stepClk();
            bus.tick = 1'b1;
            vectors++;
            if ({bus.pushB_level, bus.pushB_rise, bus.pushB_fall, bus.pushB_hold} !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_outputs k=%0d got %h want 0000", k,
                         {bus.pushB_level, bus.pushB_rise, bus.pushB_fall, bus.pushB_hold});
            end
        end
        applyReset();
    endtask

    task automatic test_rise_latency();
        applyReset();
        bus.pushB_in = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            stepClk();
            vectors++;
            if (bus.pushB_level[0] !== (k >= 7)) begin
                miscompares++;
                $display("FAIL rise_level0 k=%0d got %b want %b", k, bus.pushB_level[0], (k >= 7));
            end
            vectors++;
            if (bus.pushB_rise !== ((k == 7) ? 4'b0001 : 4'b0000)) begin
                miscompares++;
                $display("FAIL rise_pulse0 k=%0d got %b want %b", k, bus.pushB_rise,
                         ((k == 7) ? 4'b0001 : 4'b0000));
            end
        end
    endtask

    task automatic test_glitch();
        applyReset();
        bus.pushB_in = 4'b0010;
        for (int k = 1; k <= 13; k++) begin
            stepClk();
            if (k == 3) begin
                bus.pushB_in = 4'b0000;
            end
            vectors++;
            if ({bus.pushB_level[1], bus.pushB_rise[1], bus.pushB_fall[1]} !== 3'b000) begin
                miscompares++;
                $display("FAIL glitch_ch1 k=%0d got %b want 000", k,
                         {bus.pushB_level[1], bus.pushB_rise[1], bus.pushB_fall[1]});
            end
        end
    endtask

    task automatic test_hold();
        applyReset();
        bus.pushB_in = 4'b0100;
        for (int k = 1; k <= 40; k++) begin
            stepClk();
            vectors++;
            if (bus.pushB_hold[2] !== (k == 23)) begin
                miscompares++;
                $display("FAIL hold_pulse2 k=%0d got %b want %b", k, bus.pushB_hold[2], (k == 23));
            end
            vectors++;
            if (bus.pushB_rise[2] !== (k == 7)) begin
                miscompares++;
                $display("FAIL hold_rise2 k=%0d got %b want %b", k, bus.pushB_rise[2], (k == 7));
            end
        end
        bus.pushB_in = 4'b0000;
        for (int k = 1; k <= 20; k++) begin
            stepClk();
            vectors++;
            if (bus.pushB_fall[2] !== (k == 7)) begin
                miscompares++;
                $display("FAIL release_fall2 k=%0d got %b want %b", k, bus.pushB_fall[2], (k == 7));
            end
            vectors++;
            if (bus.pushB_hold[2] !== 1'b0) begin
                miscompares++;
                $display("FAIL release_hold2 k=%0d got %b want 0", k, bus.pushB_hold[2]);
            end
            vectors++;
            if (bus.pushB_level[2] !== (k < 7)) begin
                miscompares++;
                $display("FAIL release_level2 k=%0d got %b want %b", k, bus.pushB_level[2], (k < 7));
            end
        end
    endtask

    task automatic test_early_release();
        applyReset();
        bus.pushB_in = 4'b0100;
        for (int k = 1; k <= 12; k++) begin
            stepClk();
        end
        bus.pushB_in = 4'b0000;
        for (int k = 1; k <= 30; k++) begin
            stepClk();
            vectors++;
            if (bus.pushB_hold[2] !== 1'b0) begin
                miscompares++;
                $display("FAIL early_release_hold2 k=%0d got %b want 0", k, bus.pushB_hold[2]);
            end
        end
    endtask

    task automatic test_slow_tick();
        tickPeriod = 5;
        applyReset();
        bus.pushB_in = 4'b1000;
        for (int k = 1; k <= 25; k++) begin
            stepClk();
            vectors++;
            if (bus.pushB_level[3] !== (k >= 22)) begin
                miscompares++;
                $display("FAIL slow_level3 k=%0d got %b want %b", k, bus.pushB_level[3], (k >= 22));
            end
            vectors++;
            if (bus.pushB_rise[3] !== (k == 22)) begin
                miscompares++;
                $display("FAIL slow_rise3 k=%0d got %b want %b", k, bus.pushB_rise[3], (k == 22));
            end
        end
        tickPeriod = 1;
        bus.tick   = 1'b1;
    endtask

    task automatic test_reset_mid();
        applyReset();
        bus.pushB_in = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            stepClk();
        end
        reset = 1'b1;
        stepClk();
        reset = 1'b0;
        vectors++;
        if ({bus.pushB_level, bus.pushB_rise} !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_outputs got %h want 00", {bus.pushB_level, bus.pushB_rise});
        end
        for (int j = 1; j <= 9; j++) begin
            stepClk();
            vectors++;
            if (bus.pushB_level[0] !== (j >= 7)) begin
                miscompares++;
                $display("FAIL midreset_level0 j=%0d got %b want %b", j, bus.pushB_level[0], (j >= 7));
            end
            vectors++;
            if (bus.pushB_rise[0] !== (j == 7)) begin
                miscompares++;
                $display("FAIL midreset_rise0 j=%0d got %b want %b", j, bus.pushB_rise[0], (j == 7));
            end
        end
    endtask

    task automatic test_back_to_back();
        applyReset();
        bus.pushB_in = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            stepClk();
            vectors++;
            if (bus.pushB_rise !== ((k == 7) ? 4'b1111 : 4'b0000)) begin
                miscompares++;
                $display("FAIL simul_rise k=%0d got %b want %b", k, bus.pushB_rise,
                         ((k == 7) ? 4'b1111 : 4'b0000));
            end
        end
        bus.pushB_in = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            stepClk();
            vectors++;
            if (bus.pushB_fall !== ((k == 7) ? 4'b1111 : 4'b0000)) begin
                miscompares++;
                $display("FAIL simul_fall k=%0d got %b want %b", k, bus.pushB_fall,
                         ((k == 7) ? 4'b1111 : 4'b0000));
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] trackLevel;
        logic [3:0] heldPress;
        logic [3:0] prevRise;
        logic [3:0] prevFall;
        logic [3:0] prevHold;
        trackLevel = 4'b0000;
        heldPress  = 4'b0000;
        prevRise   = 4'b0000;
        prevFall   = 4'b0000;
        prevHold   = 4'b0000;
        applyReset();
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    bus.pushB_in[c] = ~bus.pushB_in[c];
                end
            end
            stepClk();
            vectors++;
            if ((bus.pushB_rise & bus.pushB_fall) !== 4'b0000) begin
                miscompares++;
                $display("FAIL bounce_rise_and_fall n=%0d rise %b fall %b want disjoint", n,
                         bus.pushB_rise, bus.pushB_fall);
            end
            vectors++;
            if (((bus.pushB_rise & prevRise) | (bus.pushB_fall & prevFall) |
                 (bus.pushB_hold & prevHold)) !== 4'b0000) begin
                miscompares++;
                $display("FAIL bounce_pulse_width n=%0d rise %b fall %b hold %b want single-cycle",
                         n, bus.pushB_rise, bus.pushB_fall, bus.pushB_hold);
            end
            vectors++;
            if (((bus.pushB_rise & trackLevel) | (bus.pushB_fall & ~trackLevel)) !== 4'b0000) begin
                miscompares++;
                $display("FAIL bounce_alternation n=%0d rise %b fall %b level_before %b", n,
                         bus.pushB_rise, bus.pushB_fall, trackLevel);
            end
            vectors++;
            if ((bus.pushB_hold & (~trackLevel | heldPress)) !== 4'b0000) begin
                miscompares++;
                $display("FAIL bounce_hold n=%0d hold %b level %b already_held %b", n,
                         bus.pushB_hold, trackLevel, heldPress);
            end
            heldPress  = (heldPress | bus.pushB_hold) & ~bus.pushB_rise;
            trackLevel = (trackLevel | bus.pushB_rise) & ~bus.pushB_fall;
            vectors++;
            if (bus.pushB_level !== trackLevel) begin
                miscompares++;
                $display("FAIL bounce_level n=%0d got %b want %b", n, bus.pushB_level, trackLevel);
            end
            prevRise = bus.pushB_rise;
            prevFall = bus.pushB_fall;
            prevHold = bus.pushB_hold;
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.tick     = 1'b0;
        bus.pushB_in = 4'b0000;
        test_reset();
        test_rise_latency();
        test_glitch();
        test_hold();
        test_early_release();
        test_slow_tick();
        test_reset_mid();
        test_back_to_back();
        test_bounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 4, number of independent push-button channels (1..32).
REQ-002 Parameter STABLE_CNT, default 4, consecutive differing ticks required to accept a level change (2..255).
REQ-003 Parameter HOLD_CNT, default 16, ticks of stable-high after press before hold pulse (STABLE_CNT..65535).
REQ-004 Port clk  in  1  single system clock; all logic on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port tick  in  1  one-clk sample-enable strobe (slow-clock replacement); filter advances only when high.
REQ-007 Port pushB_in  in  N_CH  raw asynchronous button inputs, one bit per channel.
REQ-008 Port pushB_level  out  N_CH  debounced stable level per channel.
REQ-009 Port pushB_rise  out  N_CH  one-clk pulse on accepted 0->1 change.
REQ-010 Port pushB_fall  out  N_CH  one-clk pulse on accepted 1->0 change.
REQ-011 Port pushB_hold  out  N_CH  one-clk pulse when level has been high HOLD_CNT ticks.

Function
REQ-012 Each channel shall pass pushB_in through a 2-FF synchroniser clocked every clk (independent of tick); sync output = s.
REQ-013 Per channel, on tick: if s != level, stab counter increments; if s == level, stab counter clears to 0.
REQ-014 On tick with s != level and stab counter == STABLE_CNT-1: level toggles, stab counter clears, rise or fall asserts in the next clk cycle only.
REQ-015 A glitch shorter than STABLE_CNT ticks shall produce no level change and no pulses.
REQ-016 Latency raw change -> level change: 2 clk sync + STABLE_CNT ticks (+1 clk register), exact.
REQ-017 Hold counter: clears whenever level is 0 or on rise; on tick while level==1 increments, saturating at HOLD_CNT.
REQ-018 pushB_hold pulses exactly once per press, in the clk cycle after hold counter reaches HOLD_CNT; never again until a fall and new rise.
REQ-019 A fall accepted before HOLD_CNT is reached shall suppress hold for that press.
REQ-020 Without tick, level/counters shall hold; synchroniser still runs.
REQ-021 rise, fall, hold pulses are registered outputs, never high more than 1 consecutive clk, rise and fall never simultaneous on one channel.
REQ-022 Channels fully independent; simultaneous events on multiple channels each produce their own pulses in the same cycle.
REQ-023 Counter widths: stab counter $clog2(STABLE_CNT) bits, hold counter $clog2(HOLD_CNT+1) bits; no wrap-around permitted.

Reset
REQ-024 While reset high at a clk edge: synchronisers, levels, counters cleared to 0; all outputs 0 on the following cycle.
REQ-025 Reset mid-debounce or mid-hold discards progress; a button held through reset release is re-accepted after full REQ-016 latency with a rise pulse.
REQ-026 tick during reset shall be ignored.

Structure
REQ-027 Shared package debounce_pkg holds default constants (N_CH, STABLE_CNT, HOLD_CNT defaults) and the counter-width function.
REQ-028 One sub-module debounce_ch (single channel: sync, stab counter, hold counter, pulse regs), instantiated N_CH times via generate.
REQ-029 No combinational path from any input to any output.

Verification
REQ-030 N_CH=4, STABLE_CNT=4, tick every clk; pushB_in[0] 0->1 held -> level[0]=1 and rise[0]=1 for one cycle exactly 7 clk after input edge.
REQ-031 pushB_in[1] high for 3 ticks then low -> level[1], rise[1], fall[1] stay 0 throughout.
REQ-032 HOLD_CNT=16: pushB_in[2] held 40 ticks -> single hold[2] pulse 16 ticks after rise; release -> one fall[2], no further hold.
REQ-033 tick every 5th clk, STABLE_CNT=4: pushB_in[3] rise -> level change after 4 ticks (~20 clk + sync), not earlier.
REQ-034 Assert reset 1 clk mid-count on channel 0 with input held 1 -> level stays 0, counter restarts; rise after full 4 ticks post-reset.
REQ-035 All 4 inputs rise same cycle -> rise[3:0]=4'b1111 in one cycle; random bounce regression: pulse-never-wider-than-1 and rise/fall alternation assertions hold.
